wb_arbiter: RTL and testbench

- Write-side counterpart to the core's register file: the single owner of the regfile write port (rd / write-data / write-enable).
- Merges two result sources onto that port:
  - fast ALU path, one result per cycle, no backpressure;
  - slow load-unit path, valid/ready, buffered in a small FIFO.
- Keeps a pending-write scoreboard so the issue stage stalls on RAW/WAW hazards against outstanding loads.

---
 rtl/core_pkg.sv | 14 +
 rtl/wb_fifo.sv | 61 ++++++
 rtl/wb_arbiter.sv | 117 +++++++++++
 tb/tb_wb_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core constants and the writeback entry type carried through the
// load-result FIFO and the regfile write-port registers.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = $clog2(NREGS);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries buffering load-unit results
// until the regfile write port is free.
module wb_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  wb_entry_t        i_data,
  input  logic             i_pop,
  output wb_entry_t        o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  wb_entry_t        entries_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (i_push) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (i_pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
    case ({i_push, i_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) entries_q[wrPtr_q] <= i_data;
  end

  assign o_data  = entries_q[rdPtr_q];
  assign o_count = count_q;
  assign o_full  = (count_q == CNT_W'(DEPTH));
  assign o_empty = (count_q == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Sole owner of the regfile write port: ALU results win, buffered load
// results drain when the ALU idles, and a pending-load scoreboard stalls issue.
module wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int FIFO_DEPTH = 2,
  localparam int RW        = $clog2(NREGS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_alu_valid,
  input  logic [RW-1:0]    i_alu_rd,
  input  logic [XLEN-1:0]  i_alu_data,
  input  logic             i_mem_valid,
  output logic             o_mem_ready,
  input  logic [RW-1:0]    i_mem_rd,
  input  logic [XLEN-1:0]  i_mem_data,
  input  logic             i_issue_valid,
  input  logic             i_issue_long,
  input  logic [RW-1:0]    i_issue_rd,
  input  logic [RW-1:0]    i_rs1,
  input  logic [RW-1:0]    i_rs2,
  output logic             o_stall,
  output logic             o_reg_write,
  output logic [RW-1:0]    o_rd,
  output logic [XLEN-1:0]  o_write_data,
  output logic [NREGS-1:0] o_pending
);

  import core_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic             fifoPush, fifoPop, fifoFull, fifoEmpty;
  logic [CNT_W-1:0] fifoCount;
  wb_entry_t        fifoIn, fifoHead;

  logic             regWrite_q, regWrite_d;
  logic [RW-1:0]    rd_q, rd_d;
  logic [XLEN-1:0]  writeData_q, writeData_d;
  logic [NREGS-1:0] pending_q, pending_d;
  logic [NREGS-1:0] setVec, clrVec;
  logic             issueFire;

  assign fifoIn      = '{rd: i_mem_rd, data: i_mem_data};
  assign o_mem_ready = (fifoCount < DEPTH_CNT);
  assign fifoPush    = i_mem_valid && o_mem_ready;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (fifoPush),
    .i_data (fifoIn),
    .i_pop  (fifoPop),
    .o_data (fifoHead),
    .o_count(fifoCount),
    .o_full (fifoFull),
    .o_empty(fifoEmpty)
  );

  // Strict priority: ALU first, then FIFO head; writes to x0 are swallowed.
  always_comb begin
    regWrite_d  = 1'b0;
    rd_d        = rd_q;
    writeData_d = writeData_q;
    fifoPop     = 1'b0;
    if (i_alu_valid) begin
      regWrite_d  = (i_alu_rd != '0);
      rd_d        = i_alu_rd;
      writeData_d = i_alu_data;
    end else if (!fifoEmpty) begin
      fifoPop     = 1'b1;
      regWrite_d  = (fifoHead.rd != '0);
      rd_d        = fifoHead.rd;
      writeData_d = fifoHead.data;
    end
  end

  // The FIFO-full term keeps new ALU work out so buffered loads can drain.
  assign o_stall = i_issue_valid &&
                   ((pending_q[i_rs1] && (i_rs1 != '0)) ||
                    (pending_q[i_rs2] && (i_rs2 != '0)) ||
                    (pending_q[i_issue_rd] && (i_issue_rd != '0)) ||
                    fifoFull);

  assign issueFire = i_issue_valid && i_issue_long && !o_stall && (i_issue_rd != '0);

  // A new long issue to a register drained on the same edge keeps it pending.
  always_comb begin
    setVec = '0;
    clrVec = '0;
    if (issueFire) setVec[i_issue_rd] = 1'b1;
    if (fifoPop && (fifoHead.rd != '0)) clrVec[fifoHead.rd] = 1'b1;
    pending_d = (pending_q & ~clrVec) | setVec;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      regWrite_q  <= 1'b0;
      rd_q        <= '0;
      writeData_q <= '0;
      pending_q   <= '0;
    end else begin
      regWrite_q  <= regWrite_d;
      rd_q        <= rd_d;
      writeData_q <= writeData_d;
      pending_q   <= pending_d;
    end
  end

  assign o_reg_write  = regWrite_q;
  assign o_rd         = rd_q;
  assign o_write_data = writeData_q;
  assign o_pending    = pending_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: reset, ALU path, load hazards,
// contention, scoreboard set/clear collision, WAW and mid-stream reset.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        aluValid;
  logic [4:0]  aluRd;
  logic [31:0] aluData;
  logic        memValid;
  logic        memReady;
  logic [4:0]  memRd;
  logic [31:0] memData;
  logic        issueValid, issueLong;
  logic [4:0]  issueRd, rs1, rs2;
  logic        stall, regWrite;
  logic [4:0]  rd;
  logic [31:0] writeData;
  logic [31:0] pending;

  int testsRun    = 0;
  int testsFailed = 0;

  wb_arbiter dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_alu_valid  (aluValid),
    .i_alu_rd     (aluRd),
    .i_alu_data   (aluData),
    .i_mem_valid  (memValid),
    .o_mem_ready  (memReady),
    .i_mem_rd     (memRd),
    .i_mem_data   (memData),
    .i_issue_valid(issueValid),
    .i_issue_long (issueLong),
    .i_issue_rd   (issueRd),
    .i_rs1        (rs1),
    .i_rs2        (rs2),
    .o_stall      (stall),
    .o_reg_write  (regWrite),
    .o_rd         (rd),
    .o_write_data (writeData),
    .o_pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    aluValid = 0; aluRd = 0; aluData = 0;
    memValid = 0; memRd = 0; memData = 0;
    issueValid = 0; issueLong = 0; issueRd = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    testsRun++; if (regWrite !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_write: got %0b want 0", regWrite); end
    testsRun++; if (pending !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_pending: got %h want 0", pending); end
    testsRun++; if (memReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_ready: got %0b want 1", memReady); end
    testsRun++; if (rd !== 5'd0 || writeData !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_regs: got rd=%0d data=%h want 0/0", rd, writeData); end
    step();
  endtask

  task automatic test_alu();
    aluValid = 1; aluRd = 5; aluData = 32'hDEADBEEF;
    step();
    testsRun++; if (regWrite !== 1'b1 || rd !== 5'd5 || writeData !== 32'hDEADBEEF) begin testsFailed++; $display("[TB] FAIL alu_write: got we=%0b rd=%0d data=%h want 1/5/deadbeef", regWrite, rd, writeData); end
    aluRd = 0; aluData = 32'h1;
    step();
    testsRun++; if (regWrite !== 1'b0) begin testsFailed++; $display("[TB] FAIL alu_x0: got we=%0b want 0", regWrite); end
    idle();
    step();
    testsRun++; if (regWrite !== 1'b0) begin testsFailed++; $display("[TB] FAIL alu_idle: got we=%0b want 0", regWrite); end
  endtask

  task automatic test_load_hazard();
    issueValid = 1; issueLong = 1; issueRd = 7;
    #1;
    testsRun++; if (stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL lh_issue_stall: got %0b want 0", stall); end
    step();
    idle();
    testsRun++; if (pending !== 32'h0000_0080) begin testsFailed++; $display("[TB] FAIL lh_pending_set: got %h want 00000080", pending); end
    issueValid = 1; rs1 = 7;
    #1;
    testsRun++; if (stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL lh_raw_stall: got %0b want 1", stall); end
    issueValid = 0;
    memValid = 1; memRd = 7; memData = 32'h1234;
    step();
    memValid = 0;
    testsRun++; if (regWrite !== 1'b0 || pending[7] !== 1'b1) begin testsFailed++; $display("[TB] FAIL lh_no_bypass: got we=%0b pend7=%0b want 0/1", regWrite, pending[7]); end
    step();
    testsRun++; if (regWrite !== 1'b1 || rd !== 5'd7 || writeData !== 32'h1234) begin testsFailed++; $display("[TB] FAIL lh_write: got we=%0b rd=%0d data=%h want 1/7/1234", regWrite, rd, writeData); end
    testsRun++; if (pending !== 32'h0) begin testsFailed++; $display("[TB] FAIL lh_pending_clr: got %h want 0", pending); end
    issueValid = 1; rs1 = 7;
    #1;
    testsRun++; if (stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL lh_stall_drop: got %0b want 0", stall); end
    idle();
    step();
  endtask

  task automatic test_contention();
    aluValid = 1; aluRd = 1; aluData = 32'h11;
    memValid = 1; memRd = 3; memData = 32'h33;
    step();
    memRd = 4; memData = 32'h44;
    step();
    memValid = 0;
    testsRun++; if (memReady !== 1'b0) begin testsFailed++; $display("[TB] FAIL ct_ready_low: got %0b want 0", memReady); end
    testsRun++; if (regWrite !== 1'b1 || rd !== 5'd1) begin testsFailed++; $display("[TB] FAIL ct_alu_wins: got we=%0b rd=%0d want 1/1", regWrite, rd); end
    issueValid = 1;
    #1;
    testsRun++; if (stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL ct_full_stall: got %0b want 1", stall); end
    issueValid = 0;
    step();
    testsRun++; if (memReady !== 1'b0 || rd !== 5'd1) begin testsFailed++; $display("[TB] FAIL ct_still_full: got ready=%0b rd=%0d want 0/1", memReady, rd); end
    aluValid = 0;
    step();
    testsRun++; if (regWrite !== 1'b1 || rd !== 5'd3 || writeData !== 32'h33 || memReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL ct_drain_first: got we=%0b rd=%0d data=%h ready=%0b want 1/3/33/1", regWrite, rd, writeData, memReady); end
    step();
    testsRun++; if (regWrite !== 1'b1 || rd !== 5'd4 || writeData !== 32'h44) begin testsFailed++; $display("[TB] FAIL ct_drain_second: got we=%0b rd=%0d data=%h want 1/4/44", regWrite, rd, writeData); end
    step();
    testsRun++; if (regWrite !== 1'b0) begin testsFailed++; $display("[TB] FAIL ct_empty: got we=%0b want 0", regWrite); end
    idle();
  endtask

  task automatic test_collision();
    memValid = 1; memRd = 9; memData = 32'h99;
    step();
    memValid = 0;
    issueValid = 1; issueLong = 1; issueRd = 9;
    #1;
    testsRun++; if (stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL col_issue_stall: got %0b want 0", stall); end
    step();
    idle();
    testsRun++; if (pending[9] !== 1'b1 || regWrite !== 1'b1 || rd !== 5'd9) begin testsFailed++; $display("[TB] FAIL col_set_wins: got pend9=%0b we=%0b rd=%0d want 1/1/9", pending[9], regWrite, rd); end
    memValid = 1; memRd = 9; memData = 32'h98;
    step();
    memValid = 0;
    step();
    testsRun++; if (pending !== 32'h0 || writeData !== 32'h98) begin testsFailed++; $display("[TB] FAIL col_cleanup: got pend=%h data=%h want 0/98", pending, writeData); end
  endtask

  task automatic test_waw();
    issueValid = 1; issueLong = 1; issueRd = 12;
    step();
    testsRun++; if (pending !== 32'h0000_1000) begin testsFailed++; $display("[TB] FAIL waw_set: got %h want 00001000", pending); end
    issueLong = 0; issueRd = 12;
    #1;
    testsRun++; if (stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL waw_stall: got %0b want 1", stall); end
    issueLong = 1; issueRd = 0;
    #1;
    testsRun++; if (stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL waw_x0_stall: got %0b want 0", stall); end
    step();
    testsRun++; if (pending !== 32'h0000_1000) begin testsFailed++; $display("[TB] FAIL waw_x0_pend: got %h want 00001000", pending); end
    idle();
  endtask

  task automatic test_reset_mid();
    issueValid = 1; issueLong = 1; issueRd = 20;
    step();
    issueValid = 0;
    aluValid = 1; aluRd = 2; aluData = 32'h22;
    memValid = 1; memRd = 20; memData = 32'hAA;
    step();
    memRd = 21; memData = 32'hBB;
    step();
    memValid = 0;
    testsRun++; if (memReady !== 1'b0 || pending !== 32'h0010_1000) begin testsFailed++; $display("[TB] FAIL rm_before: got ready=%0b pend=%h want 0/00101000", memReady, pending); end
    #2 rst = 1'b1;
    #1;
    testsRun++; if (regWrite !== 1'b0 || pending !== 32'h0 || memReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL rm_async: got we=%0b pend=%h ready=%0b want 0/0/1", regWrite, pending, memReady); end
    idle();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      testsRun++; if (regWrite !== 1'b0 || memReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL rm_after_%0d: got we=%0b ready=%0b want 0/1", i, regWrite, memReady); end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_hazard();
    test_contention();
    test_collision();
    test_waw();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
